wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//   MEM/WB pipeline register and writeback unit of the MIPS pipeline; sole writer of the register file.
//   Captures a completed instruction from MEM and selects the result: ALU, load data or link PC+8.
//   Sign- or zero-extends byte/half loads, then drives the regfile write port (wn/we/d).
//   Also drives a bypass port to decode, plus a retired-instruction counter for debug/perf.
// PARAMETERS
//   DW     32  data width of results and regfile entries
//   AW     5   register-number width (32 registers, r0 hardwired zero)
//   CNT_W  32  width of retired-instruction counter
// PORTS
//   clk        in   1      clock; all state updates on posedge
//   clrn       in   1      reset, asynchronous, active-low
//   hold       in   1      pipeline freeze from hazard unit; stage keeps contents, no write
//   m_valid    in   1      MEM stage presents an instruction this cycle
//   m_wreg     in   1      instruction writes a register
//   m_rn       in   AW     destination register number
//   m_sel      in   2      result select: 00 ALU, 01 load, 10 link, 11 reserved
//   m_ldtype   in   3      000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others = LW
//   m_addr_lo  in   2      effective-address bits [1:0] of the load
//   m_alu      in   DW     ALU result
//   m_mem      in   DW     raw 32-bit data-memory read word
//   m_pc8      in   DW     PC+8 for JAL/JALR
//   wn         out  AW     regfile write register number
//   we         out  1      regfile write enable
//   d          out  DW     regfile write data
//   fwd_valid  out  1      bypass valid: stage holds a register-writing instr, rn != 0
//   fwd_rn     out  AW     bypass register number (= wn)
//   fwd_d      out  DW     bypass data (= d)
//   retired    out  CNT_W  count of instructions retired since reset
// BEHAVIOUR
//   - Reset (clrn=0, async): stage valid w_v=0 and all captured fields 0; retired=0.
//     Outputs: we=0, wn=0, d=0, fwd_valid=0, fwd_rn=0, fwd_d=0.
//     If asserted mid-write, we drops immediately and the write is lost.
//   - Capture: posedge with hold=0: w_v<=m_valid; rn/wreg/sel/ldtype/addr_lo/alu/mem/pc8 <= inputs.
//     Posedge with hold=1: all stage registers keep their values; the m_* inputs are ignored.
//   - Latency: instruction on m_* at posedge N appears on wn/we/d throughout cycle N+1.
//     Outputs are pure functions of stage registers, so they are stable the whole cycle,
//     including the opposite clock edge where the regfile samples them.
//   - we = w_v & w_wreg & (w_rn!=0) & ~hold. Each instruction writes exactly once,
//     in the first non-held cycle it occupies the stage.
//   - fwd_valid = w_v & w_wreg & (w_rn!=0), independent of hold. It stays valid while held,
//     since the value is not yet in the regfile.
//   - Load extract, little-endian:
//     byte = mem[8*addr_lo +: 8]; half = addr_lo[1] ? mem[31:16] : mem[15:0].
//     LB/LH sign-extend to DW; LBU/LHU zero-extend. addr_lo[0] is ignored for halves
//     (misalignment trapped upstream).
//   - d: sel 00 -> alu; 01 -> extracted load; 10 -> pc8; 11 -> 0.
//     d is computed even when we=0.
//   - retired: +1 on each posedge with w_v=1 & hold=0, counting non-writing instrs too.
//     Wraps modulo 2^CNT_W with no saturation.
//   - rn=0 with wreg=1: no write, no bypass, still counted as retired.
//   - Bubble (m_valid=0 while hold=0): w_v=0 next cycle, so we=0 and fwd_valid=0.
// TESTING
//   1 Reset: clrn=0 mid-cycle with w_v=1, wreg=1, rn=5 -> we, fwd_valid, wn, d drop to 0
//     at once; retired=0.
//   2 ALU write: m_valid=1, wreg=1, rn=8, sel=00, alu=32'h1234_5678 at edge N
//     -> cycle N+1: we=1, wn=8, d=32'h1234_5678, fwd_valid=1; retired=1 after edge N+1.
//   3 Loads, mem=32'h80FF_7F01:
//     LB, addr_lo=2 -> d=32'hFFFF_FFFF; LBU, addr_lo=3 -> d=32'h0000_0080;
//     LH, addr_lo=2 -> d=32'hFFFF_80FF; LHU, addr_lo=0 -> d=32'h0000_7F01.
//   4 Link: sel=10, pc8=32'h0040_0010, rn=31 -> we=1, wn=31, d=32'h0040_0010.
//     Same with rn=0 -> we=0, fwd_valid=0, retired still increments.
//   5 Hold: capture rn=3, then hold=1 for 3 cycles while m_* changes
//     -> we=0, fwd_valid=1, fwd_rn=3 stable. Release -> one we=1 cycle for rn=3,
//     then the next instr; retired +1 only.
//   6 Counter wrap: CNT_W=4, retire 17 back-to-back instrs -> retired=1.

Source files
------------

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback unit: the only writer of the register file.
// It also drives the decode bypass port and a retired-instruction counter.
module wb_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             hold,
  input  logic             m_valid,
  input  logic             m_wreg,
  input  logic [AW-1:0]    m_rn,
  input  logic [1:0]       m_sel,
  input  logic [2:0]       m_ldtype,
  input  logic [1:0]       m_addr_lo,
  input  logic [DW-1:0]    m_alu,
  input  logic [DW-1:0]    m_mem,
  input  logic [DW-1:0]    m_pc8,
  output logic [AW-1:0]    wn,
  output logic             we,
  output logic [DW-1:0]    d,
  output logic             fwd_valid,
  output logic [AW-1:0]    fwd_rn,
  output logic [DW-1:0]    fwd_d,
  output logic [CNT_W-1:0] retired
);

  typedef struct packed {
    logic          v;
    logic          wreg;
    logic [AW-1:0] rn;
    logic [1:0]    sel;
    logic [2:0]    ldtype;
    logic [1:0]    addr_lo;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [DW-1:0] pc8;
  } stage_t;

  stage_t        st;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_data;
  logic          wr_ok;

  // A held stage keeps its instruction and does not retire it; it retires on the first free edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st      <= '0;
      retired <= '0;
    end else if (!hold) begin
      if (st.v) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      st <= '{v: m_valid, wreg: m_wreg, rn: m_rn, sel: m_sel, ldtype: m_ldtype,
              addr_lo: m_addr_lo, alu: m_alu, mem: m_mem, pc8: m_pc8};
    end
  end

  // Little-endian lane pick; addr_lo[0] is don't-care for halves.
  always_comb begin
    ld_byte = st.mem[{st.addr_lo, 3'b000} +: 8];
    ld_half = st.addr_lo[1] ? st.mem[31:16] : st.mem[15:0];
    case (st.ldtype)
      3'b001:  ld_data = {{(DW-8){ld_byte[7]}}, ld_byte};
      3'b010:  ld_data = {{(DW-8){1'b0}}, ld_byte};
      3'b011:  ld_data = {{(DW-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(DW-16){1'b0}}, ld_half};
      default: ld_data = st.mem;
    endcase
    case (st.sel)
      2'b00:   d = st.alu;
      2'b01:   d = ld_data;
      2'b10:   d = st.pc8;
      default: d = '0;
    endcase
  end

  assign wr_ok     = st.v & st.wreg & (st.rn != '0);
  assign we        = wr_ok & ~hold;
  assign wn        = st.rn;
  assign fwd_valid = wr_ok;
  assign fwd_rn    = st.rn;
  assign fwd_d     = d;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a pending-instruction reference model.
// A second instance with a 4-bit counter exercises counter wrap.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        clrn, hold, m_valid, m_wreg;
  logic [4:0]  m_rn;
  logic [1:0]  m_sel, m_addr_lo;
  logic [2:0]  m_ldtype;
  logic [31:0] m_alu, m_mem, m_pc8;
  logic [4:0]  wn, fwd_rn, wn4, fwd_rn4;
  logic        we, fwd_valid, we4, fwd_valid4;
  logic [31:0] d, fwd_d, d4, fwd_d4, retired;
  logic [3:0]  retired4;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .clrn(clrn), .hold(hold), .m_valid(m_valid), .m_wreg(m_wreg), .m_rn(m_rn),
    .m_sel(m_sel), .m_ldtype(m_ldtype), .m_addr_lo(m_addr_lo), .m_alu(m_alu), .m_mem(m_mem),
    .m_pc8(m_pc8), .wn(wn), .we(we), .d(d), .fwd_valid(fwd_valid), .fwd_rn(fwd_rn),
    .fwd_d(fwd_d), .retired(retired)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .clrn(clrn), .hold(hold), .m_valid(m_valid), .m_wreg(m_wreg), .m_rn(m_rn),
    .m_sel(m_sel), .m_ldtype(m_ldtype), .m_addr_lo(m_addr_lo), .m_alu(m_alu), .m_mem(m_mem),
    .m_pc8(m_pc8), .wn(wn4), .we(we4), .d(d4), .fwd_valid(fwd_valid4), .fwd_rn(fwd_rn4),
    .fwd_d(fwd_d4), .retired(retired4)
  );

  typedef struct {
    bit v, wreg;
    bit [4:0] rn;
    bit [1:0] sel, a;
    bit [2:0] ld;
    bit [31:0] alu, mem, pc8;
  } instr_t;

  instr_t      pend;   // instruction the model believes sits in the stage
  int unsigned cnt;    // instructions retired since reset
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit [31:0] load_val(instr_t x);
    bit [31:0] b, h;
    b = (x.mem >> (8 * x.a)) & 32'hFF;
    h = x.a[1] ? (x.mem >> 16) : (x.mem & 32'hFFFF);
    case (x.ld)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return x.mem;
    endcase
  endfunction

  function automatic bit [31:0] result(instr_t x);
    case (x.sel)
      2'd0:    return x.alu;
      2'd1:    return load_val(x);
      2'd2:    return x.pc8;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_out();
    bit        fv;
    bit [31:0] ed;
    fv = pend.v && pend.wreg && pend.rn != 0;
    ed = result(pend);
    chk("we", we, fv && !hold);
    chk("wn", wn, pend.rn);
    chk("d", d, ed);
    chk("fwd_valid", fwd_valid, fv);
    chk("fwd_rn", fwd_rn, pend.rn);
    chk("fwd_d", fwd_d, ed);
    chk("retired", retired, cnt);
    chk("retired4", retired4, cnt % 16);
    chk("we4", we4, fv && !hold);
    chk("wn4", wn4, pend.rn);
    chk("d4", d4, ed);
    chk("fwd4", {fwd_valid4, fwd_rn4, fwd_d4}, {fv, pend.rn, ed});
  endtask

  task automatic drive(input bit v, input bit wr, input bit [4:0] rn, input bit [1:0] sel,
                       input bit [2:0] ld, input bit [1:0] a, input bit [31:0] alu,
                       input bit [31:0] mem, input bit [31:0] pc8);
    m_valid = v; m_wreg = wr; m_rn = rn; m_sel = sel; m_ldtype = ld; m_addr_lo = a;
    m_alu = alu; m_mem = mem; m_pc8 = pc8;
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          $urandom, $urandom, $urandom);
  endtask

  // Check the current cycle, then advance one clock and update the model.
  task automatic tick();
    #1 check_out();
    @(posedge clk);
    if (!hold) begin
      if (pend.v) cnt++;
      pend = '{v: m_valid, wreg: m_wreg, rn: m_rn, sel: m_sel, ld: m_ldtype, a: m_addr_lo,
               alu: m_alu, mem: m_mem, pc8: m_pc8};
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    pend = '{default: 0};
    cnt  = 0;
    #1 check_out();
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic expect_wr(input string tag, input bit e_we, input bit [4:0] e_wn,
                           input bit [31:0] e_d);
    #1;
    chk({tag, "_we"}, we, e_we);
    chk({tag, "_wn"}, wn, e_wn);
    chk({tag, "_d"}, d, e_d);
  endtask

  int unsigned c0;

  initial begin
    hold = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Async reset mid-cycle while a write to r5 is live
    drive(1, 1, 5, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("pre_rst_we", we, 1'b1);
    #1 clrn = 1'b0;
    pend = '{default: 0};
    cnt  = 0;
    #1;
    chk("rst_we", we, 1'b0);
    chk("rst_fwd", fwd_valid, 1'b0);
    chk("rst_wn", wn, 5'd0);
    chk("rst_d", d, 32'd0);
    chk("rst_ret", retired, 32'd0);
    @(negedge clk);
    clrn = 1'b1;

    // ALU write
    drive(1, 1, 8, 0, 0, 0, 32'h1234_5678, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_wr("alu", 1, 8, 32'h1234_5678);
    chk("alu_fwd", fwd_valid, 1'b1);
    tick();
    chk("alu_ret", retired, 32'd1);

    // Load extraction
    drive(1, 1, 1, 1, 3'd1, 2, 0, 32'h80FF_7F01, 0); tick();
    drive(1, 1, 2, 1, 3'd2, 3, 0, 32'h80FF_7F01, 0); expect_wr("lb", 1, 1, 32'hFFFF_FFFF); tick();
    drive(1, 1, 3, 1, 3'd3, 2, 0, 32'h80FF_7F01, 0); expect_wr("lbu", 1, 2, 32'h0000_0080); tick();
    drive(1, 1, 4, 1, 3'd4, 0, 0, 32'h80FF_7F01, 0); expect_wr("lh", 1, 3, 32'hFFFF_80FF); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                expect_wr("lhu", 1, 4, 32'h0000_7F01); tick();

    // Link, then link to r0 (no write, still retired)
    drive(1, 1, 31, 2, 0, 0, 0, 0, 32'h0040_0010); tick();
    drive(1, 1, 0, 2, 0, 0, 0, 0, 32'h0040_0010); expect_wr("jal", 1, 31, 32'h0040_0010); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    c0 = cnt;
    #1 chk("r0_we", we, 1'b0);
    chk("r0_fwd", fwd_valid, 1'b0);
    tick();
    chk("r0_ret", retired, c0 + 1);

    // Hold for three cycles while MEM inputs churn
    drive(1, 1, 3, 0, 0, 0, 32'h0000_0333, 0, 0); tick();
    c0 = cnt;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      #1;
      chk("hold_we", we, 1'b0);
      chk("hold_fwd", {fwd_valid, fwd_rn}, {1'b1, 5'd3});
      tick();
    end
    hold = 1'b0;
    drive(1, 1, 9, 0, 0, 0, 32'h0000_0999, 0, 0);
    expect_wr("rel", 1, 3, 32'h0000_0333); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_wr("next", 1, 9, 32'h0000_0999);
    chk("hold_ret", retired, c0 + 1);
    tick();

    // 17 back-to-back instructions into a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 5'(i), 0, 0, 0, 32'(i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap4", retired4, 4'd1);
    chk("wrap32", retired, 32'd17);

    // Random traffic with occasional holds and resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      hold = ($urandom_range(0, 3) == 0);
      drive_rand();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
